// File: rtl/serial_extremum_pkg.sv
// serial_extremum_pkg
//   Shared definitions for the serial_extremum block: compare-mode encoding,
//   frame FSM state type and the index-width helper used for the frame
//   counter and out_index port.
package serial_extremum_pkg;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,  // no sample of the current frame accepted yet
    ST_ACCUM = 1'b1   // at least one sample of the current frame accepted
  } state_t;

  // Bits needed to hold a position 0..frame_len-1; never less than 1.
  function automatic int idx_width(input int frame_len);
    return (frame_len <= 2) ? 1 : $clog2(frame_len);
  endfunction

endpackage

// File: rtl/serial_extremum_compare.sv
// extremum_compare
//   Combinational "strictly better" test between two samples.
//   Ports:
//     a, b    [WIDTH-1:0]  samples; result tells whether a strictly beats b
//     mode    1            MODE_MAX: a > b, MODE_MIN: a < b
//     better  1            1 when a strictly beats b (ties -> 0)
//   SIGNED != 0 selects two's-complement interpretation, otherwise unsigned.
module extremum_compare
  import serial_extremum_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             better
);

  logic gt;
  logic lt;

  generate
    if (SIGNED != 0) begin : g_signed
      assign gt = $signed(a) > $signed(b);
      assign lt = $signed(a) < $signed(b);
    end else begin : g_unsigned
      assign gt = a > b;
      assign lt = a < b;
    end
  endgenerate

  assign better = (mode == MODE_MIN) ? lt : gt;

endmodule

// File: rtl/serial_extremum.sv
// serial_extremum
//   Streaming max/min tracker over framed sample sequences. A frame ends on an
//   accepted sample with in_last set or on the FRAME_LEN-th accepted sample;
//   the frame's extremum is registered into out_value one cycle later with a
//   single-cycle out_valid pulse.
//   Ports:
//     clk        clock, rising edge
//     rst        synchronous reset, active-low
//     enable     0 freezes all state and ignores inputs
//     in_valid   sample strobe (accepted when enable & in_valid)
//     in         [WIDTH-1:0] sample
//     in_last    accepted sample is the final one of its frame
//     mode       0 max, 1 min; taken from the first sample of each frame
//     run_value  [WIDTH-1:0] running extremum of the current frame
//     out_value  [WIDTH-1:0] extremum of the last completed frame
//     out_index  [IDX_W-1:0] position of out_value within its frame
//                (present only with SERIAL_EXTREMUM_ARGIDX_EN defined)
//     out_valid  one-cycle pulse when out_value/out_index update
module serial_extremum
  import serial_extremum_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int SIGNED    = 1,
  parameter  int FRAME_LEN = 16,
  localparam int IDX_W     = idx_width(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  input  logic             in_last,
  input  logic             mode,
  output logic [WIDTH-1:0] run_value,
  output logic [WIDTH-1:0] out_value,
`ifdef SERIAL_EXTREMUM_ARGIDX_EN
  output logic [IDX_W-1:0] out_index,
`endif
  output logic             out_valid
);

  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(FRAME_LEN - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] count, count_nxt;
  logic             mode_q, mode_nxt;
  logic [WIDTH-1:0] run_nxt, out_nxt;
  logic             valid_nxt;
  logic             accept;
  logic             frame_end;
  logic             eff_mode;
  logic             better;
  logic             take;

`ifdef SERIAL_EXTREMUM_ARGIDX_EN
  logic [IDX_W-1:0] run_idx, run_idx_nxt, out_idx_nxt;
`endif

  assign accept    = enable & in_valid;
  // count is 0 in IDLE, so FRAME_LEN==1 ends a frame on every sample.
  assign frame_end = accept & (in_last | (count == LAST_CNT));
  // The first sample of a frame uses the live mode; later ones the latched one.
  assign eff_mode  = (state == ST_IDLE) ? mode : mode_q;
  assign take      = (state == ST_IDLE) | better;

  extremum_compare #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_cmp (
    .a      (in),
    .b      (run_value),
    .mode   (eff_mode),
    .better (better)
  );

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    mode_nxt  = mode_q;
    run_nxt   = run_value;
    out_nxt   = out_value;
    valid_nxt = 1'b0;
`ifdef SERIAL_EXTREMUM_ARGIDX_EN
    run_idx_nxt = run_idx;
    out_idx_nxt = out_index;
`endif
    if (accept) begin
      if (state == ST_IDLE) mode_nxt = mode;
      if (take) begin
        run_nxt = in;
`ifdef SERIAL_EXTREMUM_ARGIDX_EN
        run_idx_nxt = count;
`endif
      end
      // Result includes the current sample, hence run_nxt rather than run_value.
      if (frame_end) begin
        out_nxt   = run_nxt;
        valid_nxt = 1'b1;
        state_nxt = ST_IDLE;
        count_nxt = '0;
`ifdef SERIAL_EXTREMUM_ARGIDX_EN
        out_idx_nxt = run_idx_nxt;
`endif
      end else begin
        state_nxt = ST_ACCUM;
        count_nxt = count + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      mode_q    <= MODE_MAX;
      run_value <= '0;
      out_value <= '0;
      out_valid <= 1'b0;
`ifdef SERIAL_EXTREMUM_ARGIDX_EN
      run_idx   <= '0;
      out_index <= '0;
`endif
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      mode_q    <= mode_nxt;
      run_value <= run_nxt;
      out_value <= out_nxt;
      out_valid <= valid_nxt;
`ifdef SERIAL_EXTREMUM_ARGIDX_EN
      run_idx   <= run_idx_nxt;
      out_index <= out_idx_nxt;
`endif
    end
  end

endmodule
